qr_cordic_row_scheduler: RTL and testbench

Sequences one tall matrix (N_ROWS rows × D_WIDTH columns, (DATA_WIDTH,10) fixed-point) into the QR_CORDIC systolic array. Rows are accepted from an upstream source via a valid/ready handshake and buffered in full. The block then issues them to the core as one gap-free stream of N_ROWS consecutive valid cycles. It collects the D_WIDTH R-rows the core returns, forwards each with an index, and signals done or timeout. It sits between the matrix source and QR_CORDIC and is the only driver of the core's a_ij/valid_i.

---
 rtl/qr_sched_pkg.sv | 31 +++
 rtl/qr_row_buffer.sv | 31 +++
 rtl/qr_cordic_row_scheduler.sv | 166 ++++++++++++++++
 tb/tb_qr_cordic_row_scheduler.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qr_sched_pkg.sv
// qr_sched_pkg: shared constants for the QR_CORDIC row scheduler.
// FSM state codes, default geometry and width helpers.
package qr_sched_pkg;

  localparam int DEF_DATA_WIDTH = 20;
  localparam int DEF_D_WIDTH    = 4;
  localparam int DEF_N_ROWS     = 8;
  localparam int DEF_TIMEOUT    = 64;
  localparam int ROW_W = DEF_DATA_WIDTH * DEF_D_WIDTH;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_LOAD  = 3'd1;
  localparam state_t S_ISSUE = 3'd2;
  localparam state_t S_DRAIN = 3'd3;
  localparam state_t S_DONE  = 3'd4;

  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

  function automatic int row_w(input int dw, input int n);
    return dw * n;
  endfunction

  localparam int PTR_W = clog2_min1(DEF_N_ROWS);
  localparam int IDX_W = clog2_min1(DEF_D_WIDTH);
  localparam int TMO_W = clog2_min1(DEF_TIMEOUT);

endpackage

// File: rtl/qr_row_buffer.sv
// qr_row_buffer: N_ROWS x ROW_W register file, one write port and
// one registered read port that returns zero when not enabled.
module qr_row_buffer #(
  parameter int ROW_W  = 80,
  parameter int N_ROWS = 8,
  parameter int PTR_W  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [PTR_W-1:0] wr_addr,
  input  logic [ROW_W-1:0] wr_data,
  input  logic             rd_en,
  input  logic [PTR_W-1:0] rd_addr,
  output logic [ROW_W-1:0] rd_data
);

  logic [ROW_W-1:0] mem [N_ROWS];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read register doubles as the core's a_ij, so it idles at zero.
  always_ff @(posedge clk) begin
    if (rst)        rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
    else            rd_data <= '0;
  end

endmodule

// File: rtl/qr_cordic_row_scheduler.sv
// qr_cordic_row_scheduler: buffers one matrix, streams it to QR_CORDIC,
// collects R rows. Optional QR_SCHED_PERF_EN adds perf_cycles.
module qr_cordic_row_scheduler
  import qr_sched_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int D_WIDTH    = DEF_D_WIDTH,
  parameter int N_ROWS     = DEF_N_ROWS,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_WIDTH*D_WIDTH-1:0] in_row,
  output logic [DATA_WIDTH*D_WIDTH-1:0] core_a_ij,
  output logic                          core_valid_i,
  input  logic                          core_valid_o,
  input  logic [DATA_WIDTH*D_WIDTH-1:0] core_out_r,
  output logic                          r_valid,
  output logic [DATA_WIDTH*D_WIDTH-1:0] r_row,
  output logic [clog2_min1(D_WIDTH)-1:0] r_idx,
  output logic                          busy,
  output logic                          done,
  output logic                          err_timeout
`ifdef QR_SCHED_PERF_EN
 ,output logic [15:0]                   perf_cycles
`endif
);

  localparam int RW = row_w(DATA_WIDTH, D_WIDTH);
  localparam int PW = clog2_min1(N_ROWS);
  localparam int IW = clog2_min1(D_WIDTH);
  localparam int CW = $clog2(D_WIDTH + 1);
  localparam int TW = clog2_min1(TIMEOUT);

  localparam logic [PW-1:0] LAST_ROW = PW'(N_ROWS - 1);
  localparam logic [CW-1:0] LAST_OUT = CW'(D_WIDTH - 1);
  localparam logic [CW-1:0] ALL_OUT  = CW'(D_WIDTH);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  state_t        state;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] out_cnt;
  logic [TW-1:0] tmo;
  logic          accept;
  logic          issuing;
  logic          capture;
  logic          go;
  logic [RW-1:0] rd_data;

  assign in_ready  = (state == S_LOAD);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign issuing   = (state == S_ISSUE);
  assign accept    = in_ready && in_valid;
  assign go        = (state == S_IDLE) && start;
  assign core_a_ij = rd_data;

  assign capture = core_valid_o
                && (issuing || state == S_DRAIN)
                && (out_cnt < ALL_OUT);

  qr_row_buffer #(
    .ROW_W  (RW),
    .N_ROWS (N_ROWS),
    .PTR_W  (PW)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (accept),
    .wr_addr (wr_ptr),
    .wr_data (in_row),
    .rd_en   (issuing),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      tmo         <= '0;
      err_timeout <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state       <= S_LOAD;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            err_timeout <= 1'b0;
          end
        end
        S_LOAD: begin
          if (accept) begin
            if (wr_ptr == LAST_ROW) begin
              wr_ptr <= '0;
              state  <= S_ISSUE;
            end else begin
              wr_ptr <= wr_ptr + 1'b1;
            end
          end
        end
        S_ISSUE: begin
          tmo <= '0;
          if (rd_ptr == LAST_ROW) begin
            rd_ptr <= '0;
            state  <= S_DRAIN;
          end else begin
            rd_ptr <= rd_ptr + 1'b1;
          end
        end
        S_DRAIN: begin
          // A capture on the expiry cycle wins over the timeout.
          if (out_cnt == ALL_OUT || (capture && out_cnt == LAST_OUT)) begin
            state <= S_DONE;
          end else if (capture) begin
            tmo <= '0;
          end else if (tmo == TMO_LAST) begin
            err_timeout <= 1'b1;
            state       <= S_DONE;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      core_valid_i <= 1'b0;
      r_valid      <= 1'b0;
      r_row        <= '0;
      r_idx        <= '0;
      out_cnt      <= '0;
    end else begin
      core_valid_i <= issuing;
      r_valid      <= capture;
      if (go) begin
        out_cnt <= '0;
      end else if (capture) begin
        r_row   <= core_out_r;
        r_idx   <= out_cnt[IW-1:0];
        out_cnt <= out_cnt + 1'b1;
      end
    end
  end

`ifdef QR_SCHED_PERF_EN
  always_ff @(posedge clk) begin
    if (rst || go) begin
      perf_cycles <= '0;
    end else if ((issuing || state == S_DRAIN) && perf_cycles != 16'hFFFF) begin
      perf_cycles <= perf_cycles + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_qr_cordic_row_scheduler.sv
// tb_qr_cordic_row_scheduler: vector table, hand sequences and random
// runs checked cycle by cycle against an event-timeline model.
`timescale 1ns/1ps
module tb_qr_cordic_row_scheduler;

  localparam int DW   = 20;
  localparam int DWID = 4;
  localparam int NR   = 8;
  localparam int TMO  = 64;
  localparam int RW   = DW * DWID;
  localparam int MAXC = 1024;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic [RW-1:0] in_row;
  logic [RW-1:0] core_a_ij;
  logic          core_valid_i;
  logic          core_valid_o;
  logic [RW-1:0] core_out_r;
  logic          r_valid;
  logic [RW-1:0] r_row;
  logic [1:0]    r_idx;
  logic          busy;
  logic          done;
  logic          err_timeout;
`ifdef QR_SCHED_PERF_EN
  logic [15:0]   perf_cycles;
`endif

  always #5 clk = ~clk;

  qr_cordic_row_scheduler #(
    .DATA_WIDTH (DW),
    .D_WIDTH    (DWID),
    .N_ROWS     (NR),
    .TIMEOUT    (TMO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_row       (in_row),
    .core_a_ij    (core_a_ij),
    .core_valid_i (core_valid_i),
    .core_valid_o (core_valid_o),
    .core_out_r   (core_out_r),
    .r_valid      (r_valid),
    .r_row        (r_row),
    .r_idx        (r_idx),
    .busy         (busy),
    .done         (done),
    .err_timeout  (err_timeout)
`ifdef QR_SCHED_PERF_EN
   ,.perf_cycles  (perf_cycles)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Per-cycle stimulus and expectations, indexed by cycle since start.
  logic          iv     [MAXC];
  logic          st     [MAXC];
  logic          cv     [MAXC];
  logic [RW-1:0] ir     [MAXC];
  logic [RW-1:0] cd     [MAXC];
  logic          exp_rv [MAXC];
  logic [RW-1:0] exp_rr [MAXC];
  int            exp_ri [MAXC];
  logic [RW-1:0] rows   [NR];

  typedef struct {
    int stall;
    int ncap;
    int first;
    int gap;
    int exp_rows;
    bit exp_err;
  } vec_t;

  vec_t vt [9];

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%b want=%b t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chkw(input string nm, input logic [RW-1:0] act,
                      input logic [RW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [RW-1:0] rnd();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[RW-1:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // stall: 0 none, 1 random, 2 two-cycle gaps before accepts 3 and 6.
  // Capture k is on edge A+NR+first+k*gap, A = edge of the 8th accept.
  task automatic run_case(input int stall, input int ncap, input int first,
                          input int gap, input bit basic,
                          output int n_rv, output bit saw_err);
    int stall_b [NR];
    int capq [$];
    int n, a, r_ref, cnt, done_at, e, o;
    bit err;
    logic [DW-1:0] lane;
    for (int i = 0; i < MAXC; i++) begin
      iv[i] = 1'b0; st[i] = 1'b0; cv[i] = 1'b0;
      ir[i] = rnd(); cd[i] = rnd();
      exp_rv[i] = 1'b0; exp_rr[i] = '0; exp_ri[i] = 0;
    end
    for (int k = 0; k < NR; k++) begin
      if (stall == 1)                        stall_b[k] = int'($urandom_range(0, 3));
      else if (stall == 2 && (k == 2 || k == 5)) stall_b[k] = 2;
      else                                   stall_b[k] = 0;
      lane = DW'((k + 1) << 10);
      rows[k] = basic ? {DWID{lane}} : rnd();
    end
    n = 1;
    for (int k = 0; k < NR; k++) begin
      n += stall_b[k];
      iv[n] = 1'b1;
      ir[n] = rows[k];
      n++;
    end
    a = n;
    for (int i = a; i < MAXC; i++) iv[i] = 1'($urandom_range(0, 1));
    e = a + NR + first;
    for (int i = 0; i < ncap; i++) begin
      capq.push_back(e);
      cv[e-1] = 1'b1;
      if (basic) cd[e-1] = RW'(13017);
      e += gap;
    end
    // Timeline model: R rows captured in order until D_WIDTH, or TIMEOUT
    // cycles pass in DRAIN since entry or since the last capture.
    r_ref = a + NR; cnt = 0; done_at = -1; err = 1'b0;
    foreach (capq[i]) begin
      e = capq[i];
      if (e <= a + NR) begin
        if (cnt < DWID) begin
          exp_rv[e] = 1'b1; exp_rr[e] = cd[e-1]; exp_ri[e] = cnt;
          cnt++;
        end
      end else begin
        if (cnt == DWID) break;
        if (e > r_ref + TMO) break;
        exp_rv[e] = 1'b1; exp_rr[e] = cd[e-1]; exp_ri[e] = cnt;
        cnt++;
        r_ref = e;
        if (cnt == DWID) begin
          done_at = e;
          break;
        end
      end
    end
    if (done_at < 0) begin
      if (cnt == DWID) done_at = a + NR + 1;
      else begin
        done_at = r_ref + TMO;
        err = 1'b1;
      end
    end
    st[0] = 1'b1;
    for (int i = 1; i <= done_at; i++) st[i] = ($urandom_range(0, 7) == 0);
    n_rv = 0;
    saw_err = 1'b0;
    for (int m = 0; m <= done_at + 1; m++) begin
      start = st[m]; in_valid = iv[m]; in_row = ir[m];
      core_valid_o = cv[m]; core_out_r = cd[m];
      step();
      o = m + 1;
      chk1("in_ready", in_ready, o < a);
      chk1("core_valid_i", core_valid_i, o > a && o <= a + NR);
      chkw("core_a_ij", core_a_ij,
           (o > a && o <= a + NR) ? rows[o-a-1] : '0);
      chk1("busy", busy, o <= done_at);
      chk1("done", done, o == done_at);
      chk1("err_timeout", err_timeout, (o >= done_at) ? err : 1'b0);
      chk1("r_valid", r_valid, exp_rv[o]);
      if (exp_rv[o]) begin
        chkw("r_row", r_row, exp_rr[o]);
        chkw("r_idx", RW'(r_idx), RW'(exp_ri[o]));
      end
`ifdef QR_SCHED_PERF_EN
      if (o == done_at + 1) chkw("perf_cycles", RW'(perf_cycles), RW'(done_at - a));
`endif
      if (r_valid === 1'b1) n_rv++;
      if (o == done_at + 1) saw_err = err_timeout;
    end
    start = 1'b0; in_valid = 1'b0; core_valid_o = 1'b0;
  endtask

  initial begin
    int n_rv;
    bit saw_err;
    int gsel;
    logic [RW-1:0] hr [NR];

    vt[0] = '{0, 4, 1, 1, 4, 1'b0};
    vt[1] = '{2, 4, 3, 5, 4, 1'b0};
    vt[2] = '{0, 2, 2, 4, 2, 1'b1};
    vt[3] = '{0, 6, 1, 2, 4, 1'b0};
    vt[4] = '{0, 4, -5, 1, 4, 1'b0};
    vt[5] = '{0, 1, TMO, 1, 1, 1'b1};
    vt[6] = '{0, 1, TMO + 1, 1, 0, 1'b1};
    vt[7] = '{1, 4, 1, TMO, 4, 1'b0};
    vt[8] = '{0, 3, 1, TMO + 1, 1, 1'b1};

    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_row = '0;
    core_valid_o = 1'b0; core_out_r = '0;
    repeat (3) step();
    chk1("rst_in_ready", in_ready, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_valid_i", core_valid_i, 1'b0);
    chk1("rst_r_valid", r_valid, 1'b0);
    chk1("rst_err", err_timeout, 1'b0);
    chkw("rst_a_ij", core_a_ij, '0);
    chkw("rst_r_row", r_row, '0);
    chkw("rst_r_idx", RW'(r_idx), '0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 9; i++) begin
      run_case(vt[i].stall, vt[i].ncap, vt[i].first, vt[i].gap, i == 0,
               n_rv, saw_err);
      chkw($sformatf("vec%0d_rows", i), RW'(n_rv), RW'(vt[i].exp_rows));
      chk1($sformatf("vec%0d_err", i), saw_err, vt[i].exp_err);
    end

    // Reset while the 4th row is on the core interface.
    for (int k = 0; k < NR; k++) hr[k] = rnd();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < NR; k++) begin
      in_valid = 1'b1;
      in_row = hr[k];
      step();
    end
    in_valid = 1'b0;
    repeat (4) step();
    chk1("mid_valid_i", core_valid_i, 1'b1);
    chkw("mid_row3", core_a_ij, hr[3]);
    rst = 1'b1;
    step();
    chk1("mid_rst_valid_i", core_valid_i, 1'b0);
    chk1("mid_rst_busy", busy, 1'b0);
    chk1("mid_rst_in_ready", in_ready, 1'b0);
    chkw("mid_rst_a_ij", core_a_ij, '0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 20; i++) begin
      gsel = int'($urandom_range(0, 3));
      run_case(1, int'($urandom_range(0, 6)), int'($urandom_range(0, 17)) - 7,
               (gsel == 0) ? TMO - 2 + int'($urandom_range(0, 4))
                           : int'($urandom_range(1, 8)),
               1'b0, n_rv, saw_err);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
